sample_stream_fifo: RTL

Parametrised successor to the single-register stream path: a DATA_WIDTH-wide, DEPTH-entry first-word-fall-through FIFO between a valid/ready input stream and a valid/ready output stream. Reports occupancy and supports a synchronous flush. Used as a cocotb test design for handshake, backpressure and wrap-around checks.

---
 rtl/sample_stream_pkg.sv | 15 +
 rtl/sample_stream_fifo_mem.sv | 33 +++
 rtl/sample_stream_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/sample_stream_pkg.sv
// Shared constants, types and helpers for the sample stream FIFO.
package sample_stream_pkg;

  localparam int STAT_W = 16;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [STAT_W-1:0] stall;
    logic [STAT_W-1:0] backpressure;
  } stream_stats_t;

endpackage

// File: rtl/sample_stream_fifo_mem.sv
// Register-array storage for the sample stream FIFO: synchronous write,
// asynchronous read, synchronous active-low clear of every entry.
module sample_stream_fifo_mem
  import sample_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sample_stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy and synchronous flush.
// Define SAMPLE_STREAM_FIFO_STATS_EN to add saturating stall/backpressure counters.
module sample_stream_fifo
  import sample_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int LEVEL_W   = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stream_in_valid,
  output logic                  stream_in_ready,
  input  logic [DATA_WIDTH-1:0] stream_in_data,
  output logic                  stream_out_valid,
  input  logic                  stream_out_ready,
  output logic [DATA_WIDTH-1:0] stream_out_data,
  output logic [LEVEL_W-1:0]    level,
  output logic                  full,
  output logic                  empty
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_count,
  output logic [STAT_W-1:0]     backpressure_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wrPtr_q, wrPtr_d;
  logic [AW-1:0]      rdPtr_q, rdPtr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               doPush;
  logic               doPop;

  // Status comes only from the level register, so ready/valid never loop back.
  assign full             = (level_q == LEVEL_W'(DEPTH));
  assign empty            = (level_q == '0);
  assign level            = level_q;
  assign stream_in_ready  = !full;
  assign stream_out_valid = !empty;
  assign doPush           = stream_in_valid && stream_in_ready;
  assign doPop            = stream_out_valid && stream_out_ready;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // A push coinciding with flush must not land in storage.
  sample_stream_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (doPush && !flush),
    .wr_addr_i(wrPtr_q),
    .wr_data_i(stream_in_data),
    .rd_addr_i(rdPtr_q),
    .rd_data_o(stream_out_data)
  );

`ifdef SAMPLE_STREAM_FIFO_STATS_EN
  stream_stats_t stats_q, stats_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    stats_d = stats_q;
    if (stream_out_valid && !stream_out_ready && (stats_q.stall != '1))
      stats_d.stall = stats_q.stall + 1'b1;
    if (stream_in_valid && !stream_in_ready && (stats_q.backpressure != '1))
      stats_d.backpressure = stats_q.backpressure + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign stall_count        = stats_q.stall;
  assign backpressure_count = stats_q.backpressure;
`endif

endmodule
